random_range_gen: RTL and testbench

RANDOM_RANGE_GEN -- requirements
Module: random_range_gen

---
 rtl/random_range_gen.sv | 160 ++++++++++++++++
 tb/tb_random_range_gen.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/random_range_gen.sv
// Bounded random number generator: a free-running Galois LFSR feeds a
// rejection-sampling draw that returns a value in the inclusive range [lo, hi].
module random_range_gen #(
   parameter int                LFSR_W = 16,
   parameter int                OUT_W  = 8,
   parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_in,
   input  logic              req,
   input  logic [OUT_W-1:0]  lo,
   input  logic [OUT_W-1:0]  hi,
   input  logic              ack,
   output logic [OUT_W-1:0]  y,
   output logic              y_valid,
   output logic              busy,
   output logic              err,
   output logic [LFSR_W-1:0] state_q
);

   localparam logic [31:0] MASK32 = (LFSR_W == 8)  ? 32'h0000_00B8 :
                                    (LFSR_W == 16) ? 32'h0000_B400 :
                                    (LFSR_W == 24) ? 32'h00E1_0000 :
                                                     32'h8020_0003;
   localparam logic [LFSR_W-1:0] MASK = MASK32[LFSR_W-1:0];

   // Handshake: y is offered while y_valid=1 and is consumed on the first
   // rising edge where ack=1; y/y_valid do not move until that edge.
   typedef enum logic [1:0] {IDLE, DRAW, HOLD} fsm_t;

   fsm_t              fsm_q, fsm_d;
   logic [LFSR_W-1:0] lfsr_d;
   logic [OUT_W-1:0]  lo_q, lo_d;
   logic [OUT_W:0]    span_q, span_d;
   logic [OUT_W-1:0]  rmask_q, rmask_d;
   logic [3:0]        attempt_q, attempt_d;
   logic [OUT_W-1:0]  y_d;
   logic              y_valid_d;
   logic              err_d;

   logic [OUT_W-1:0]  diff;
   logic [OUT_W-1:0]  fill;
   logic [OUT_W-1:0]  cand;
   logic [OUT_W-1:0]  cand_fold;
   logic              cand_ok;
   logic              take_req;
   logic              launch;
   logic              range_ok;

   // A zero seed would lock the LFSR, so it is replaced by SEED.
   always_comb begin
      lfsr_d = state_q >> 1;
      if (seed_load) begin
         lfsr_d = (seed_in == '0) ? SEED : seed_in;
      end else if (state_q[0]) begin
         lfsr_d = (state_q >> 1) ^ MASK;
      end
   end

   // fill has every bit at or below the top set bit of hi-lo, which is the
   // smallest 2^n-1 covering span-1.
   always_comb begin
      diff     = hi - lo;
      range_ok = (lo <= hi);
      fill     = '0;
      for (int i = 0; i < OUT_W; i++) begin
         fill[i] = |(diff >> i);
      end
   end

   always_comb begin
      cand      = state_q[OUT_W-1:0] & rmask_q;
      cand_ok   = ({1'b0, cand} < span_q);
      cand_fold = cand_ok ? cand : OUT_W'({1'b0, cand} - span_q);
   end

   // seed_load always beats a same-edge request.
   assign take_req = req && !seed_load;
   assign launch   = take_req && ((fsm_q == IDLE) || ((fsm_q == HOLD) && ack));

   always_comb begin
      fsm_d     = fsm_q;
      lo_d      = lo_q;
      span_d    = span_q;
      rmask_d   = rmask_q;
      attempt_d = attempt_q;
      y_d       = y;
      y_valid_d = y_valid;
      err_d     = 1'b0;

      case (fsm_q)
         IDLE: begin
            fsm_d = IDLE;
         end
         DRAW: begin
            if (seed_load) begin
               fsm_d     = IDLE;
               attempt_d = '0;
            end else if (cand_ok || (attempt_q == 4'd15)) begin
               y_d       = lo_q + cand_fold;
               y_valid_d = 1'b1;
               attempt_d = '0;
               fsm_d     = HOLD;
            end else begin
               attempt_d = attempt_q + 4'd1;
            end
         end
         HOLD: begin
            if (ack) begin
               y_valid_d = 1'b0;
               fsm_d     = IDLE;
            end
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase

      if (launch) begin
         if (range_ok) begin
            fsm_d     = DRAW;
            lo_d      = lo;
            span_d    = {1'b0, diff} + {{OUT_W{1'b0}}, 1'b1};
            rmask_d   = fill;
            attempt_d = '0;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q     <= IDLE;
         state_q   <= SEED;
         lo_q      <= '0;
         span_q    <= '0;
         rmask_q   <= '0;
         attempt_q <= '0;
         y         <= '0;
         y_valid   <= 1'b0;
         err       <= 1'b0;
      end else begin
         fsm_q     <= fsm_d;
         state_q   <= lfsr_d;
         lo_q      <= lo_d;
         span_q    <= span_d;
         rmask_q   <= rmask_d;
         attempt_q <= attempt_d;
         y         <= y_d;
         y_valid   <= y_valid_d;
         err       <= err_d;
      end
   end

   assign busy = (fsm_q == DRAW);

endmodule

// File: tb/tb_random_range_gen.sv
// Bench for random_range_gen: vector table, corner-case sequences and random
// requests checked against an LFSR-sequence reference model.
module tb_random_range_gen;

   localparam logic [15:0] SEED_V = 16'hACE1;
   localparam logic [15:0] MASK_V = 16'hB400;

   logic        clk = 1'b0;
   logic        rst;
   logic        seed_load;
   logic [15:0] seed_in;
   logic        req;
   logic [7:0]  lo;
   logic [7:0]  hi;
   logic        ack;
   logic [7:0]  y;
   logic        y_valid;
   logic        busy;
   logic        err;
   logic [15:0] state_q;

   int checks = 0;
   int errors = 0;

   random_range_gen dut (
      .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
      .req(req), .lo(lo), .hi(hi), .ack(ack), .y(y), .y_valid(y_valid),
      .busy(busy), .err(err), .state_q(state_q)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] nxt(input logic [15:0] s);
      if (s % 2 == 1) return (s / 2) ^ MASK_V;
      return s / 2;
   endfunction

   // Reference LFSR: advances every edge, reloads on seed_load.
   logic [15:0] m_lfsr;
   always @(posedge clk or posedge rst) begin
      if (rst) m_lfsr <= SEED_V;
      else if (seed_load) m_lfsr <= (seed_in != 16'd0) ? seed_in : SEED_V;
      else m_lfsr <= nxt(m_lfsr);
   end

   always @(negedge clk) begin
      if (!rst) check("state_q_track", state_q, m_lfsr);
   end

   // Walk the LFSR sequence the draw will see and apply the range rule.
   task automatic predict(input logic [15:0] l0, input logic [7:0] l, input logic [7:0] h,
                          output int y_e, output int lat_e);
      int span;
      int p;
      int cand;
      logic [15:0] s;
      span = int'(h) - int'(l) + 1;
      p = 1;
      s = l0;
      y_e = 0;
      lat_e = 0;
      while (p < span) p = p * 2;
      for (int k = 0; k < 16; k++) begin
         s = nxt(s);
         cand = int'(s % 256) & (p - 1);
         if (cand < span) begin
            y_e = int'(l) + cand;
            lat_e = k + 2;
            return;
         end
         if (k == 15) begin
            y_e = int'(l) + cand - span;
            lat_e = 17;
         end
      end
   endtask

   task automatic do_req(input logic [7:0] l, input logic [7:0] h, input bit exp_err);
      int y_e, lat_e, lat, busy_n;
      y_e = 0;
      lat_e = 0;
      if (!exp_err) predict(m_lfsr, l, h, y_e, lat_e);
      lo = l;
      hi = h;
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      lo = 8'($urandom);
      hi = 8'($urandom);
      lat = 1;
      busy_n = 0;
      if (exp_err) begin
         check("err_pulse", err, 1'b1);
         check("err_y_valid", y_valid, 1'b0);
         check("err_busy", busy, 1'b0);
         @(negedge clk);
         check("err_width", err, 1'b0);
         check("err_busy_after", busy, 1'b0);
         check("err_y_valid_after", y_valid, 1'b0);
         return;
      end
      while (!y_valid && lat < 20) begin
         if (busy) busy_n++;
         @(negedge clk);
         lat++;
      end
      check("req_y_valid", y_valid, 1'b1);
      check("req_y", y, y_e);
      check("req_latency", lat, lat_e);
      check("req_busy_cycles", busy_n, lat_e - 1);
      check("req_in_range", (y >= l) && (y <= h), 1'b1);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("ack_clears_valid", y_valid, 1'b0);
   endtask

   typedef struct {
      logic [7:0] lo;
      logic [7:0] hi;
      bit         exp_err;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int y_e, lat_e, lat;
      logic [7:0] rl, rh;

      vecs[0] = '{8'd33,  8'd33,  1'b0};
      vecs[1] = '{8'd0,   8'd255, 1'b0};
      vecs[2] = '{8'd50,  8'd10,  1'b1};
      vecs[3] = '{8'd1,   8'd44,  1'b0};
      vecs[4] = '{8'd200, 8'd200, 1'b0};
      vecs[5] = '{8'd255, 8'd0,   1'b1};
      vecs[6] = '{8'd0,   8'd0,   1'b0};
      vecs[7] = '{8'd128, 8'd131, 1'b0};

      rst = 1'b1; seed_load = 1'b0; seed_in = 16'd0; req = 1'b0;
      lo = 8'd0; hi = 8'd0; ack = 1'b0;
      #1;
      check("rst_y", y, 8'd0);
      check("rst_y_valid", y_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_state", state_q, SEED_V);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("seq0", state_q, 16'hACE1);
      @(negedge clk);
      check("seq1", state_q, 16'hE270);
      @(negedge clk);
      check("seq2", state_q, 16'h7138);
      @(negedge clk);
      check("seq3", state_q, 16'h389C);

      for (int i = 0; i < 8; i++) do_req(vecs[i].lo, vecs[i].hi, vecs[i].exp_err);

      // Single-value range, then hold without ack; a HOLD-time req is dropped.
      lo = 8'd33; hi = 8'd33; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      check("h33_busy", busy, 1'b1);
      check("h33_not_yet", y_valid, 1'b0);
      @(negedge clk);
      check("h33_valid", y_valid, 1'b1);
      check("h33_y", y, 8'd33);
      check("h33_busy_off", busy, 1'b0);
      for (int i = 0; i < 5; i++) begin
         req = (i == 1);
         lo = 8'd0; hi = 8'd255;
         @(negedge clk);
         check("h33_hold_y", y, 8'd33);
         check("h33_hold_valid", y_valid, 1'b1);
         check("h33_hold_busy", busy, 1'b0);
      end
      req = 1'b0;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("h33_ack", y_valid, 1'b0);

      // seed_load with zero seed aborts a draw.
      lo = 8'd0; hi = 8'd200; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      check("abort_busy_in", busy, 1'b1);
      seed_load = 1'b1; seed_in = 16'd0;
      @(negedge clk);
      seed_load = 1'b0;
      check("abort_state", state_q, 16'hACE1);
      check("abort_busy", busy, 1'b0);
      check("abort_valid", y_valid, 1'b0);
      @(negedge clk);
      check("abort_valid_late", y_valid, 1'b0);
      check("abort_busy_late", busy, 1'b0);

      // seed_load and req together in IDLE: the request is ignored.
      seed_load = 1'b1; seed_in = 16'h1234; req = 1'b1; lo = 8'd0; hi = 8'd10;
      @(negedge clk);
      seed_load = 1'b0; req = 1'b0;
      check("seedreq_state", state_q, 16'h1234);
      check("seedreq_busy", busy, 1'b0);
      check("seedreq_err", err, 1'b0);
      @(negedge clk);
      check("seedreq_valid", y_valid, 1'b0);

      // seed_load during HOLD leaves the result alone.
      lo = 8'd7; hi = 8'd7; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      seed_load = 1'b1; seed_in = 16'h5555;
      @(negedge clk);
      seed_load = 1'b0;
      check("hseed_y", y, 8'd7);
      check("hseed_valid", y_valid, 1'b1);
      check("hseed_state", state_q, 16'h5555);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("hseed_ack", y_valid, 1'b0);

      // Asynchronous reset while holding a result.
      lo = 8'd99; hi = 8'd99; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      check("arst_pre_valid", y_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", y_valid, 1'b0);
      check("arst_y", y, 8'd0);
      check("arst_busy", busy, 1'b0);
      check("arst_state", state_q, SEED_V);
      @(negedge clk);
      rst = 1'b0;

      // 200 back-to-back requests in [1,44], req held high, ack one cycle late.
      lo = 8'd1; hi = 8'd44; req = 1'b1;
      predict(m_lfsr, 8'd1, 8'd44, y_e, lat_e);
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         ack = 1'b0;
         if (n > 0) check("b2b_ack_clears", y_valid, 1'b0);
         lat = 1;
         while (!y_valid && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         check("b2b_valid", y_valid, 1'b1);
         check("b2b_y", y, y_e);
         check("b2b_range", (y >= 8'd1) && (y <= 8'd44), 1'b1);
         check("b2b_latency", lat, lat_e);
         check("b2b_lat_bound", (lat >= 2) && (lat <= 17), 1'b1);
         predict(m_lfsr, 8'd1, 8'd44, y_e, lat_e);
         if (n == 199) req = 1'b0;
         ack = 1'b1;
      end
      @(negedge clk);
      ack = 1'b0;
      check("b2b_end_valid", y_valid, 1'b0);
      check("b2b_end_busy", busy, 1'b0);

      // Random ranges, including some inverted ones.
      for (int i = 0; i < 40; i++) begin
         rl = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 4) == 0) rh = 8'($urandom_range(0, 255));
         else rh = 8'($urandom_range(int'(rl), 255));
         do_req(rl, rh, rl > rh);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
